serial_bit_tx: RTL and testbench
================================

// Module: serial_bit_tx
// PURPOSE
//   Framed serial transmitter: takes a WIDTH-bit parallel word over a valid/ready handshake and
//   drives it onto a 1-bit line as start, data, optional parity and stop bits, each held BAUD_DIV clocks.
//   Transmit end of the 1-bit data line that our single-bit D flip-flop sampler captures on clk.
//   One clock domain only; no receiver logic in this block.
// PARAMETERS
//   WIDTH      8  data bits per frame (>=1)
//   BAUD_DIV   4  clocks per serial bit (>=1; 1 = one bit per clock)
//   MSB_FIRST  0  0: data bit 0 sent first; 1: data bit WIDTH-1 sent first
//   PARITY_EN  1  1: insert one even-parity bit after the data bits; 0: no parity bit
//   STOP_BITS  1  number of stop bits (1 or 2)
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low reset (0 = reset asserted)
//   tx_data   in   WIDTH  word to send; sampled only on handshake
//   tx_valid  in   1      word on tx_data is valid
//   tx_ready  out  1      block accepts a word this cycle (high only in IDLE)
//   data_out  out  1      serial line, registered; idle level 1
//   busy      out  1      frame in progress (state != IDLE)
//   done      out  1      one-cycle pulse when a frame completes
// BEHAVIOUR
//   Reset values: data_out=1, tx_ready=1, busy=0, done=0, state=IDLE, counters=0.
//   Reset mid-frame: all outputs and state return to reset values immediately. The frame is dropped; no done pulse.
//   States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//   Handshake: accept when tx_valid && tx_ready at a rising edge. On that edge:
//     - latch tx_data into the shift register
//     - compute parity = ^tx_data
//     - enter START; data_out=0 from that edge
//   tx_valid while busy is ignored. tx_data changes after acceptance do not affect the frame.
//   Bit timing: a baud counter runs 0..BAUD_DIV-1. Each bit holds data_out for exactly BAUD_DIV clocks.
//     The state/bit advances on the edge where the counter equals BAUD_DIV-1.
//   DATA: sends WIDTH bits in the order set by MSB_FIRST. A bit index counts 0..WIDTH-1.
//   PARITY: data_out = even parity, i.e. XOR of all data bits (the total count of ones over data+parity is even).
//   STOP: data_out=1 for STOP_BITS*BAUD_DIV clocks.
//     On the final edge: go to IDLE, done=1 for exactly one cycle, tx_ready=1, busy=0.
//   Frame length: (1 + WIDTH + PARITY_EN + STOP_BITS) * BAUD_DIV clocks, from the accept edge to the IDLE edge.
//   Back-to-back: tx_ready is low for the whole frame and rises on the IDLE edge.
//     A word held valid is accepted on the next edge. Between frames there is exactly one extra
//     clock of idle (data_out=1), and done coincides with that cycle.
//   BAUD_DIV=1: the counter is held at 0, so every state lasts one clock; the same rules apply.
//   busy = (state != IDLE). tx_ready = !busy. Outputs never glitch: all outputs are registered or a decode of the state register.
// TESTING
//   1. Assert reset=0 mid-stream, then release -> data_out=1, tx_ready=1, busy=0, done=0 while reset is low and after release.
//   2. Defaults, send 8'hA5 -> line: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1.
//      Each bit lasts 4 clocks, 44 clocks in total. done pulses once.
//   3. MSB_FIRST=1, PARITY_EN=1, send 8'h01 -> data bits 0,0,0,0,0,0,0,1, parity bit 1, one stop bit.
//   4. Hold tx_valid=1 with 8'h3C then 8'hC3 (BAUD_DIV=1, STOP_BITS=2) ->
//      two frames of 12 clocks each, separated by 1 idle clock; tx_ready is low throughout each frame.
//   5. Pulse tx_valid with 8'hFF while busy -> ignored. The current frame is unchanged and no second frame is sent.
//   6. Assert reset=0 during DATA bit 3 of 8'h5A -> data_out=1 immediately; no done.
//      A new 8'h5A after release is sent correctly.

Source files
------------

// File: rtl/serial_bit_tx.sv
// serial_bit_tx
//   Framed serial transmitter. A WIDTH-bit word is accepted over a valid/ready
//   handshake and sent on a 1-bit line as: start (0), data bits, optional even
//   parity bit, then STOP_BITS stop bits (1). Each bit is held for BAUD_DIV clocks.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   tx_data   in   word to send, sampled on the accept edge only
//   tx_valid  in   tx_data is valid
//   tx_ready  out  word can be accepted this cycle (IDLE only)
//   data_out  out  registered serial line, idles high
//   busy      out  frame in progress
//   done      out  one-cycle pulse on frame completion
module serial_bit_tx #(
    parameter int WIDTH     = 8,
    parameter int BAUD_DIV  = 4,
    parameter int MSB_FIRST = 0,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             data_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BMAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_baud;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             r_parity;
    logic             r_data_out;
    logic             r_done;

    logic             w_tick;
    logic             w_accept;
    logic             w_first;
    logic [WIDTH-1:0] w_shifted;

    // With BAUD_DIV=1 the counter is pinned at 0, so w_tick is always true.
    assign w_tick   = (r_baud == CW'(BAUD_DIV - 1));
    assign w_accept = tx_valid && (r_state == S_IDLE);

    // The next bit to send always sits at the shift register's outgoing end.
    always_comb begin
        w_first   = r_shift[0];
        w_shifted = r_shift >> 1;
        if (MSB_FIRST != 0) begin
            w_first   = r_shift[WIDTH-1];
            w_shifted = r_shift << 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_data_out <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if ((r_state == S_IDLE) || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= tx_data;
                        r_parity   <= ^tx_data;
                        r_bit      <= '0;
                        r_data_out <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_data_out <= w_first;
                        r_shift    <= w_shifted;
                        r_bit      <= '0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit == BW'(WIDTH - 1)) begin
                            r_bit <= '0;
                            if (PARITY_EN != 0) begin
                                r_data_out <= r_parity;
                                r_state    <= S_PARITY;
                            end else begin
                                r_data_out <= 1'b1;
                                r_state    <= S_STOP;
                            end
                        end else begin
                            r_bit      <= r_bit + BW'(1);
                            r_data_out <= w_first;
                            r_shift    <= w_shifted;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_data_out <= 1'b1;
                        r_bit      <= '0;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_bit == BW'(STOP_BITS - 1)) begin
                            r_bit      <= '0;
                            r_data_out <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                end
                default: begin
                    r_data_out <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE);
    assign tx_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx
//   Directed bench for serial_bit_tx. Three instances cover the default
//   configuration, MSB-first ordering, and BAUD_DIV=1 with two stop bits.
//   Expected line sequences are hand-written constants, first bit at the MSB.
module tb_serial_bit_tx;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data0, tx_data1, tx_data2;
    logic       tx_valid0, tx_valid1, tx_valid2;
    logic       ready0, ready1, ready2;
    logic       dout0, dout1, dout2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    int checks;
    int failures;

    serial_bit_tx #(.WIDTH(8), .BAUD_DIV(4), .MSB_FIRST(0), .PARITY_EN(1), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(ready0), .data_out(dout0), .busy(busy0), .done(done0)
    );

    serial_bit_tx #(.WIDTH(8), .BAUD_DIV(4), .MSB_FIRST(1), .PARITY_EN(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(ready1), .data_out(dout1), .busy(busy1), .done(done1)
    );

    serial_bit_tx #(.WIDTH(8), .BAUD_DIV(1), .MSB_FIRST(0), .PARITY_EN(1), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(ready2), .data_out(dout2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel, output logic d, output logic r, output logic b, output logic dn);
        case (sel)
            0:       begin d = dout0; r = ready0; b = busy0; dn = done0; end
            1:       begin d = dout1; r = ready1; b = busy1; dn = done1; end
            default: begin d = dout2; r = ready2; b = busy2; dn = done2; end
        endcase
    endtask

    task automatic chk_idle(input string tag, input int sel, input logic exp_done);
        logic d, r, b, dn;
        sample(sel, d, r, b, dn);
        chk({tag, " data_out"}, 32'(d), 32'd1);
        chk({tag, " tx_ready"}, 32'(r), 32'd1);
        chk({tag, " busy"}, 32'(b), 32'd0);
        chk({tag, " done"}, 32'(dn), 32'(exp_done));
    endtask

    // Entered at the falling edge right after the accept edge; leaves at the
    // falling edge after the IDLE edge (or one later when tail is set).
    task automatic run_frame(input int sel, input logic [15:0] exp, input int len,
                             input int baud, input int poke, input bit tail);
        logic d, r, b, dn;
        for (int i = 0; i < len * baud; i++) begin
            sample(sel, d, r, b, dn);
            chk($sformatf("u%0d clk%0d data_out", sel, i), 32'(d), 32'(exp[len - 1 - i / baud]));
            chk($sformatf("u%0d clk%0d busy", sel, i), 32'(b), 32'd1);
            chk($sformatf("u%0d clk%0d tx_ready", sel, i), 32'(r), 32'd0);
            chk($sformatf("u%0d clk%0d done", sel, i), 32'(dn), 32'd0);
            if (i == poke) begin
                tx_valid0 = 1'b1;
                tx_data0  = 8'hFF;
            end else if ((poke >= 0) && (i == poke + 1)) begin
                tx_valid0 = 1'b0;
            end
            @(negedge clk);
        end
        chk_idle($sformatf("u%0d end", sel), sel, 1'b1);
        if (tail) begin
            @(negedge clk);
            chk_idle($sformatf("u%0d after", sel), sel, 1'b0);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        tx_data0  = '0; tx_data1 = '0; tx_data2 = '0;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_valid2 = 1'b0;

        // Reset held low, then released.
        repeat (2) @(negedge clk);
        chk_idle("rst low u0", 0, 1'b0);
        chk_idle("rst low u1", 1, 1'b0);
        chk_idle("rst low u2", 2, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("rst rel u0", 0, 1'b0);
        chk_idle("rst rel u2", 2, 1'b0);

        // A5, LSB first, even parity 0: 0 | 1,0,1,0,0,1,0,1 | 0 | 1
        tx_data0  = 8'hA5;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        tx_data0  = 8'h00;
        run_frame(0, 16'b01010010101, 11, 4, -1, 1'b1);

        // 01, MSB first: 0 | 0,0,0,0,0,0,0,1 | 1 | 1
        tx_data1  = 8'h01;
        tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
        run_frame(1, 16'b00000000111, 11, 4, -1, 1'b1);

        // Back-to-back with valid held, BAUD_DIV=1, two stop bits.
        tx_data2  = 8'h3C;
        tx_valid2 = 1'b1;
        @(negedge clk);
        tx_data2  = 8'hC3;
        run_frame(2, 16'b000111100011, 12, 1, -1, 1'b0);
        @(negedge clk);
        tx_valid2 = 1'b0;
        run_frame(2, 16'b011000011011, 12, 1, -1, 1'b1);
        repeat (3) @(negedge clk);
        chk_idle("u2 no third frame", 2, 1'b0);

        // FF pulsed mid-frame is ignored; no second frame follows.
        tx_data0  = 8'hA5;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        run_frame(0, 16'b01010010101, 11, 4, 10, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("u0 post-ignore busy%0d", k), 32'(busy0), 32'd0);
            chk($sformatf("u0 post-ignore line%0d", k), 32'(dout0), 32'd1);
        end

        // Reset during data bit 3 of 5A, then resend 5A.
        tx_data0  = 8'h5A;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        repeat (17) @(negedge clk);
        chk("u0 bit3 line", 32'(dout0), 32'd1);
        chk("u0 bit3 busy", 32'(busy0), 32'd1);
        reset = 1'b0;
        #1;
        chk_idle("u0 async rst", 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle($sformatf("u0 post-rst%0d", k), 0, 1'b0);
        end
        tx_data0  = 8'h5A;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        run_frame(0, 16'b00101101001, 11, 4, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
